// File: rtl/fp_add_pkg.sv
// Shared definitions for the fp_add datapath: operation encoding and the
// pipeline geometry helpers used by the pipelined CLA adder/subtractor.
package fp_add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when WIDTH splits evenly into at least one BLOCK-bit slice.
  function automatic bit params_legal(input int width, input int block);
    return (block >= 1) && (width >= block) && ((width % block) == 0);
  endfunction

  // Number of pipeline stages; falls back to 1 so an illegal setting still
  // elaborates far enough to report the parameter error.
  function automatic int calc_nstage(input int width, input int block);
    if (params_legal(width, block)) begin
      return width / block;
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice. Every internal carry is
// formed directly from generate/propagate terms and the slice carry-in.
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g_s;
  logic [BLOCK-1:0] p_s;
  logic [BLOCK:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Sum-of-products lookahead: c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1:0]cin.
  always_comb begin
    logic term_s;
    logic prop_s;
    term_s = 1'b0;
    prop_s = 1'b1;
    c_s    = {(BLOCK+1){1'b0}};
    c_s[0] = cin;
    for (int i = 1; i <= BLOCK; i++) begin
      term_s = 1'b0;
      prop_s = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        term_s = term_s | (prop_s & g_s[j]);
        prop_s = prop_s & p_s[j];
      end
      c_s[i] = term_s | (prop_s & cin);
    end
  end

  assign s     = p_s ^ c_s[BLOCK-1:0];
  assign cout  = c_s[BLOCK];
  assign c_msb = c_s[BLOCK-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor. One BLOCK-bit slice is resolved
// per stage; finished low slices, untouched high operand bits and the slice
// carry travel down the pipe. A single global stall freezes every stage while
// a result waits at the output.
module pipe_cla_addsub
  import fp_add_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSTAGE = calc_nstage(WIDTH, BLOCK);
  localparam int LAST   = NSTAGE - 1;

  if (!params_legal(WIDTH, BLOCK)) begin : g_bad_params
    $error("pipe_cla_addsub: WIDTH must be a positive multiple of BLOCK");
  end

  // Per-stage inputs: stage 0 is fed from the ports, stage k from register k-1.
  logic [WIDTH-1:0] a_src_s [NSTAGE];
  logic [WIDTH-1:0] b_src_s [NSTAGE];
  logic [WIDTH-1:0] s_src_s [NSTAGE];
  logic             c_src_s [NSTAGE];
  logic             v_src_s [NSTAGE];

  logic [WIDTH-1:0] s_last_s;
  logic             c_last_s;
  logic             m_last_s;
  logic             adv_s;
  logic [WIDTH-1:0] beff_s;
  logic             c0_s;

  logic             out_valid_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic             ovf_r;
  logic             zero_r;

  assign adv_s    = ~out_valid_r | out_ready;
  assign in_ready = adv_s;

  // Operand preparation: subtract is a + ~b + 1, so cin is ignored then.
  always_comb begin
    beff_s = b;
    c0_s   = cin;
    case (sub)
      OP_ADD: begin
        beff_s = b;
        c0_s   = cin;
      end
      OP_SUB: begin
        beff_s = ~b;
        c0_s   = 1'b1;
      end
      default: begin
        beff_s = b;
        c0_s   = cin;
      end
    endcase
  end

  assign a_src_s[0] = a;
  assign b_src_s[0] = beff_s;
  assign s_src_s[0] = {WIDTH{1'b0}};
  assign c_src_s[0] = c0_s;
  assign v_src_s[0] = in_valid;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int LO = k * BLOCK;

    logic [BLOCK-1:0] slice_s;
    logic             slice_c_s;
    logic             slice_m_s;
    logic [WIDTH-1:0] s_new_s;

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a     (a_src_s[k][LO +: BLOCK]),
      .b     (b_src_s[k][LO +: BLOCK]),
      .cin   (c_src_s[k]),
      .s     (slice_s),
      .cout  (slice_c_s),
      .c_msb (slice_m_s)
    );

    // Merge this slice's sum into the partial result carried so far.
    always_comb begin
      s_new_s = s_src_s[k];
      s_new_s[LO +: BLOCK] = slice_s;
    end

    if (k < LAST) begin : g_reg
      logic             v_r;
      logic [WIDTH-1:0] a_r;
      logic [WIDTH-1:0] b_r;
      logic [WIDTH-1:0] s_r;
      logic             c_r;

      // Stage register: valid moves on every advance, data only with a real op.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          v_r <= 1'b0;
          a_r <= {WIDTH{1'b0}};
          b_r <= {WIDTH{1'b0}};
          s_r <= {WIDTH{1'b0}};
          c_r <= 1'b0;
        end else if (adv_s) begin
          v_r <= v_src_s[k];
          if (v_src_s[k]) begin
            a_r <= a_src_s[k];
            b_r <= b_src_s[k];
            s_r <= s_new_s;
            c_r <= slice_c_s;
          end
        end
      end

      assign a_src_s[k+1] = a_r;
      assign b_src_s[k+1] = b_r;
      assign s_src_s[k+1] = s_r;
      assign c_src_s[k+1] = c_r;
      assign v_src_s[k+1] = v_r;
    end else begin : g_last
      assign s_last_s = s_new_s;
      assign c_last_s = slice_c_s;
      assign m_last_s = slice_m_s;
    end
  end

  // Output register: the last slice plus flags, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      zero_r      <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= v_src_s[LAST];
      if (v_src_s[LAST]) begin
        sum_r  <= s_last_s;
        cout_r <= c_last_s;
        ovf_r  <= c_last_s ^ m_last_s;
        zero_r <= ~|s_last_s;
      end
    end
  end

  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_pipe_cla_addsub.sv
// Scoreboard bench for pipe_cla_addsub (WIDTH=32, BLOCK=8, four stages).
module tb_pipe_cla_addsub;

  localparam int WIDTH  = 32;
  localparam int BLOCK  = 8;
  localparam int NSTAGE = WIDTH / BLOCK;
  localparam int LAT    = NSTAGE - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = 32'd0;
  logic [WIDTH-1:0] b = 32'd0;
  logic             cin = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } res_t;

  res_t exp_q[$];
  res_t obs_q[$];
  int   exp_cyc[$];
  int   obs_cyc[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  pipe_cla_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arithmetic written from the definitions of add/sub/flags.
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic ci, input logic sb);
    res_t r;
    if (sb) begin
      r.sum  = x - y;
      r.cout = (x >= y);
      r.ovf  = (x[31] != y[31]) && (r.sum[31] != x[31]);
    end else begin
      r.sum  = x + y + {31'd0, ci};
      r.cout = ({1'b0, x} + {1'b0, y} + {32'd0, ci}) > 33'h0_FFFF_FFFF;
      r.ovf  = (x[31] == y[31]) && (r.sum[31] != x[31]);
    end
    r.zero = (r.sum == 32'd0);
    return r;
  endfunction

  // Handshakes seen at the negedge complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); exp_cyc.delete(); obs_q.delete(); obs_cyc.delete();
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        exp_cyc.push_back(cyc + 1);
      end
      if (out_valid && out_ready) begin
        obs_q.push_back(res_t'({sum, cout, ovf, zero}));
        obs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_op(input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic sb);
    bit accepted = 1'b0;
    in_valid = 1'b1; a = x; b = y; cin = ci; sub = sb;
    for (int t = 0; t < 40 && !accepted; t++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (!accepted) begin
      failures++;
      $display("FAIL drive_accept: in_ready=0 for 40 cycles, required 1");
    end
  endtask

  task automatic wait_results(input int n);
    for (int t = 0; t < 60 && obs_q.size() < n; t++) begin
      @(posedge clk); #1;
    end
    checks++;
    if (obs_q.size() < n) begin
      failures++;
      $display("FAIL result_timeout: got %0d results, required %0d", obs_q.size(), n);
    end
  endtask

  task automatic pop_pair(output res_t o, output res_t e, output int oc,
                          output int ec, output bit ok);
    ok = (obs_q.size() > 0) && (exp_q.size() > 0);
    o = '0; e = '0; oc = 0; ec = 0;
    if (ok) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      oc = obs_cyc.pop_front(); ec = exp_cyc.pop_front();
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'h1; cin = 1'b0; sub = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sum !== 32'd0 || cout !== 1'b0 || ovf !== 1'b0 || zero !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs: valid=%b sum=%h cout=%b ovf=%b zero=%b, required all 0",
                 out_valid, sum, cout, ovf, zero);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: in_ready=%b, required 1", in_ready);
    end
    @(posedge clk); #1;
    idle(8);
    checks++;
    if (obs_q.size() != 0 || out_valid !== 1'b0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL reset_no_output: results=%0d valid=%b sum=%h, required 0/0/0",
               obs_q.size(), out_valid, sum);
    end
  endtask

  task automatic test_add();
    logic [31:0] xa [3] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0010};
    logic [31:0] xb [3] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0020};
    logic        xc [3] = '{1'b0, 1'b0, 1'b1};
    logic [34:0] want [3] = '{{32'h0000_0000, 3'b101}, {32'h8000_0000, 3'b010},
                              {32'h0000_0031, 3'b000}};
    res_t o, e; int oc, ec; bit ok;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_op(xa[i], xb[i], xc[i], 1'b0);
    idle(LAT + 2);
    wait_results(3);
    for (int i = 0; i < 3; i++) begin
      pop_pair(o, e, oc, ec, ok);
      if (!ok) break;
      checks++;
      if (o !== res_t'(want[i])) begin
        failures++;
        $display("FAIL add_const[%0d]: got %h, required %h", i, o, want[i]);
      end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL add_model[%0d]: got %h, required %h", i, o, e);
      end
      checks++;
      if (oc - ec != LAT) begin
        failures++;
        $display("FAIL add_latency[%0d]: got %0d, required %0d", i, oc - ec, LAT);
      end
    end
  endtask

  task automatic test_sub();
    logic [31:0] xa [2] = '{32'h8000_0000, 32'h0000_0003};
    logic [31:0] xb [2] = '{32'h0000_0001, 32'h0000_0005};
    logic [34:0] want [2] = '{{32'h7FFF_FFFF, 3'b110}, {32'hFFFF_FFFE, 3'b000}};
    res_t o, e; int oc, ec; bit ok;
    for (int i = 0; i < 2; i++) drive_op(xa[i], xb[i], 1'b1, 1'b1);
    idle(LAT + 2);
    wait_results(2);
    for (int i = 0; i < 2; i++) begin
      pop_pair(o, e, oc, ec, ok);
      if (!ok) break;
      checks++;
      if (o !== res_t'(want[i])) begin
        failures++;
        $display("FAIL sub_const[%0d]: got %h, required %h", i, o, want[i]);
      end
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL sub_model[%0d]: got %h, required %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t o, e; int oc, ec, first; bit ok;
    first = 0;
    for (int i = 0; i < 8; i++)
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    idle(LAT + 2);
    wait_results(8);
    for (int i = 0; i < 8; i++) begin
      pop_pair(o, e, oc, ec, ok);
      if (!ok) break;
      if (i == 0) first = oc;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b_model[%0d]: got %h, required %h", i, o, e);
      end
      checks++;
      if (oc - ec != LAT || oc != first + i) begin
        failures++;
        $display("FAIL b2b_timing[%0d]: latency %0d cycle %0d, required %0d and %0d",
                 i, oc - ec, oc, LAT, first + i);
      end
    end
  endtask

  task automatic test_stall();
    res_t o, e; int oc, ec; bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < NSTAGE; i++)
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    in_valid = 1'b1; a = $urandom; b = $urandom; cin = 1'b1; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || exp_q.size() != NSTAGE) begin
        failures++;
        $display("FAIL stall_ctrl[%0d]: in_ready=%b valid=%b accepted=%0d, required 0/1/%0d",
                 i, in_ready, out_valid, exp_q.size(), NSTAGE);
      end
      checks++;
      if (exp_q.size() == 0 || res_t'({sum, cout, ovf, zero}) !== exp_q[0]) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got %h, required head of scoreboard",
                 i, {sum, cout, ovf, zero});
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    idle(LAT + 3);
    wait_results(NSTAGE + 1);
    for (int i = 0; i < NSTAGE + 1; i++) begin
      pop_pair(o, e, oc, ec, ok);
      if (!ok) break;
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stall_drain[%0d]: got %h, required %h", i, o, e);
      end
    end
    idle(4);
    checks++;
    if (obs_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL stall_count: extra results %0d missing %0d, required 0/0",
               obs_q.size(), exp_q.size());
    end
  endtask

  task automatic test_stall_reset();
    out_ready = 1'b0;
    for (int i = 0; i < NSTAGE; i++)
      drive_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    idle(2);
    in_valid = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== 32'd0) begin
      failures++;
      $display("FAIL midreset_state: in_ready=%b valid=%b sum=%h, required 1/0/0",
               in_ready, out_valid, sum);
    end
    @(posedge clk); #1;
    idle(8);
    checks++;
    if (obs_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_flush: results=%0d valid=%b, required 0/0",
               obs_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_stall();
    test_stall_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
